// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam int unsigned DIV_DEFAULT_WIDTH = 32;

    // Width of an iteration counter that must hold the value WIDTH.
    function automatic int unsigned div_cnt_width(input int unsigned width);
        return int'($clog2(width + 1));
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient LSB when it does not go negative.
module div_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction on WIDTH+1 bits; the top bit is the borrow/sign.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Parametrised iterative restoring divider (DIV/DIVU) with signed mode, cancel,
// defined divide-by-zero results and a busy/ready handshake.
// Optional feature macro: DIV_ZERO_FAST_EN (divide by zero skips the CALC phase).
module div_iter_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CntW = div_cnt_width(WIDTH);

    div_state_t       state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dbz_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             ready_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic             sa;
    logic             sb;
    logic             dbz_in;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;

    // Operand signs and magnitudes; in unsigned mode the raw bits pass through.
    always_comb begin
        sa      = signed_i & dividend_i[WIDTH-1];
        sb      = signed_i & divisor_i[WIDTH-1];
        dvd_mag = sa ? -dividend_i : dividend_i;
        dvs_mag = sb ? -divisor_i : divisor_i;
        dbz_in  = (divisor_i == '0);
    end

    div_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    // Sign fix-up of the unsigned result; divide by zero overrides both values.
    // Most-negative / -1 needs no special case: |MIN| is MIN as unsigned and the
    // quotient sign is positive, so the unsigned result already wraps correctly.
    always_comb begin
        if (dbz_q) begin
            quotient_d  = '1;
            remainder_d = dvd_q;
        end else begin
            quotient_d  = qneg_q ? -quo_q : quo_q;
            remainder_d = rneg_q ? -rem_q : rem_q;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dbz_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (cancel_i) begin
            // Flush wins over everything, results keep their previous values.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rem_q  <= '0;
                        quo_q  <= dvd_mag;
                        dvs_q  <= dvs_mag;
                        dvd_q  <= dividend_i;
                        qneg_q <= sa ^ sb;
                        rneg_q <= sa;
                        dbz_q  <= dbz_in;
                        cnt_q  <= CntW'(WIDTH);
                        busy_q <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        state_q <= dbz_in ? FIX : CALC;
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient_q  <= quotient_d;
                    remainder_q <= remainder_d;
                    busy_q      <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: WIDTH=32 and WIDTH=8 instances.
module tb_div_iter_unit;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif
    localparam int LAT   = 34;
    localparam int LIMIT = 60;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, sgn, cancel;
    logic [31:0] a, b;
    logic        busy, ready;
    logic [31:0] q, r;

    logic        start8, sgn8, cancel8;
    logic [7:0]  a8, b8;
    logic        busy8, ready8;
    logic [7:0]  q8, r8;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [31:0] last_q, last_r;

    div_iter_unit #(.WIDTH(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .signed_i   (sgn),
        .cancel_i   (cancel),
        .dividend_i (a),
        .divisor_i  (b),
        .busy_o     (busy),
        .ready_o    (ready),
        .quotient_o (q),
        .remainder_o(r)
    );

    div_iter_unit #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start8),
        .signed_i   (sgn8),
        .cancel_i   (cancel8),
        .dividend_i (a8),
        .divisor_i  (b8),
        .busy_o     (busy8),
        .ready_o    (ready8),
        .quotient_o (q8),
        .remainder_o(r8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference divide, independent of the restoring algorithm.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                  output logic [31:0] mq, output logic [31:0] mr);
        if (y == 32'd0) begin
            mq = '1;
            mr = x;
        end else if (!s) begin
            mq = x / y;
            mr = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            mq = x;
            mr = 32'd0;
        end else begin
            mq = $signed(x) / $signed(y);
            mr = $signed(x) % $signed(y);
        end
    endfunction

    // Called at a negedge: that cycle is cycle 0 (start accepted at its end).
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input int lat,
                          input string tag, input bit hold);
        int   n;
        int   busy_bad;
        exp_t e;
        sb.push_back('{eq, er, tag});
        a = x; b = y; sgn = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            a = ~x; b = y + 32'd1; sgn = ~s;
        end else begin
            start = 1'b0;
        end
        n = 1;
        busy_bad = 0;
        while (ready !== 1'b1 && n < LIMIT) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_q"}, 64'(q), 64'(e.q));
            check({e.tag, "_r"}, 64'(r), 64'(e.r));
            last_q = e.q;
            last_r = e.r;
        end
        @(negedge clk);
        check({tag, "_pulse"}, {62'd0, ready, busy}, 64'd0);
        check({tag, "_hold_q"}, 64'(q), 64'(last_q));
    endtask

    initial begin
        logic [31:0] x, y, mq, mr;
        logic        s;
        int          n;
        int          rdy_seen;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; cancel = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sgn8 = 1'b0; cancel8 = 1'b0; a8 = '0; b8 = '0;
        last_q = '0; last_r = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_q", 64'(q), 64'd0);
        check("reset_r", 64'(r), 64'd0);
        check("reset8", {46'd0, busy8, ready8, q8, r8}, 64'd0);

        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, LAT, "u100_7", 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT, "s_m7_2", 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, LAT, "u_fff9_2", 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, LAT, "s_ovf", 1'b0);
        run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, ZLAT, "u_dbz", 1'b0);
        run_op(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, ZLAT, "s_dbz", 1'b0);
        run_op(32'hFFFF_FFF6, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF6, ZLAT, "s_dbz_neg", 1'b0);
        run_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, LAT, "hold_start", 1'b1);

        // Cancel in cycle 10 of 100/7, restart 9/3 in cycle 11.
        a = 32'd100; b = 32'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rdy_seen = 0;
        for (int i = 1; i < 10; i++) begin
            if (ready === 1'b1) rdy_seen++;
            @(negedge clk);
        end
        check("cancel_busy_c10", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy_c11", 64'(busy), 64'd0);
        check("cancel_no_ready", 64'(rdy_seen) + 64'(ready), 64'd0);
        check("cancel_keep_q", 64'(q), 64'(last_q));
        check("cancel_keep_r", 64'(r), 64'(last_r));
        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, LAT, "after_cancel", 1'b0);

        // Reset in cycle 5 of an operation.
        a = 32'd100; b = 32'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out", {30'd0, busy, ready, q}, 64'd0);
        check("midrst_r", 64'(r), 64'd0);
        rdy_seen = 0;
        repeat (40) begin
            if (ready === 1'b1 || busy === 1'b1) rdy_seen++;
            @(negedge clk);
        end
        check("midrst_quiet", 64'(rdy_seen), 64'd0);
        last_q = '0;
        last_r = '0;

        // Randomised operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            if (i == 0) y = 32'd0;
            s = 1'($urandom_range(0, 1));
            model(x, y, s, mq, mr);
            run_op(x, y, s, mq, mr, (y == 32'd0) ? ZLAT : LAT, "rand", 1'b0);
        end

        // WIDTH=8 instance: 200/9 unsigned.
        a8 = 8'd200; b8 = 8'd9; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (ready8 !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("w8_lat", 64'(n), 64'd10);
        check("w8_q", 64'(q8), 64'd22);
        check("w8_r", 64'(r8), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
